// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for the multiplexed 7-segment bus: settles, decodes and frames 8 scanned digits.
// Optional hex-glyph decoding (A,b,C,d,E,F) is enabled by defining SEG_DECODE_HEX_EN.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  anode,
  input  logic [6:0]  seg,
  output logic [31:0] digits,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        frame_valid,
  output logic        time_valid,
  output logic        seg_err,
  output logic        anode_err,
  output logic        scan_lost
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_CHANGE} state_t;

  // Returns {undecodable, digit}; patterns are active-low, bit6 = a ... bit0 = g.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b0, 4'h0};
      7'b1001111: decode = {1'b0, 4'h1};
      7'b0010010: decode = {1'b0, 4'h2};
      7'b0000110: decode = {1'b0, 4'h3};
      7'b1001100: decode = {1'b0, 4'h4};
      7'b0100100: decode = {1'b0, 4'h5};
      7'b0100000: decode = {1'b0, 4'h6};
      7'b0001111: decode = {1'b0, 4'h7};
      7'b0000000: decode = {1'b0, 4'h8};
      7'b0000100: decode = {1'b0, 4'h9};
`ifdef SEG_DECODE_HEX_EN
      7'b0001000: decode = {1'b0, 4'hA};
      7'b1100000: decode = {1'b0, 4'hB};
      7'b0110001: decode = {1'b0, 4'hC};
      7'b1000010: decode = {1'b0, 4'hD};
      7'b0110000: decode = {1'b0, 4'hE};
      7'b0111000: decode = {1'b0, 4'hF};
      7'b1111111: decode = {1'b0, 4'hF};
`else
      7'b1111111: decode = {1'b0, 4'hE};
`endif
      default:    decode = {1'b1, 4'hF};
    endcase
  endfunction

  function automatic logic [7:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    t = (tens > 4'd9) ? 4'hF : tens;
    o = (ones > 4'd9) ? 4'hF : ones;
    to_bin = 8'(t) * 8'd10 + 8'(o);
  endfunction

  // Two-flop synchronizer plus one history stage used for change detection and capture.
  logic [7:0] anode_m, anode_s, anode_p;
  logic [6:0] seg_m, seg_s, seg_p;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_m <= '1;
      anode_s <= '1;
      anode_p <= '1;
      seg_m   <= '1;
      seg_s   <= '1;
      seg_p   <= '1;
    end else begin
      anode_m <= anode;
      anode_s <= anode_m;
      anode_p <= anode_s;
      seg_m   <= seg;
      seg_s   <= seg_m;
      seg_p   <= seg_s;
    end
  end

  state_t          state_q, state_d;
  logic [7:0]      settle_q, settle_d;
  logic [8:0]      settle_inc;
  logic [TW-1:0]   timeout_q;
  logic [7:0]      mask_q, mask_d;
  logic [7:0]      cap_anode;
  logic [3:0]      pending [8];
  logic            bus_changed, one_cold, capture, capture_ok, timeout_hit, frame_done;
  logic [2:0]      cap_pos;
  logic [4:0]      dec;
  logic [31:0]     frame_digits;
  logic [7:0]      hours_full, minutes_full, seconds_full;
  logic            digits_ok, time_ok;

  assign bus_changed = ({anode_s, seg_s} != {anode_p, seg_p});
  assign one_cold    = $onehot(~anode_p);
  assign capture     = (state_q == CAPTURE);
  assign capture_ok  = capture && one_cold;
  assign dec         = decode(seg_p);
  assign frame_done  = (mask_q == 8'hFF);
  assign timeout_hit = !capture_ok && (timeout_q == TW'(TIMEOUT_CYCLES - 1));
  assign settle_inc  = {1'b0, settle_q} + 9'd1;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cap_pos  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_p[i]) cap_pos = 3'(i);
    end
    case (state_q)
      IDLE: begin
        if (bus_changed) begin
          state_d  = SETTLE;
          settle_d = 8'd1;
        end
      end
      SETTLE: begin
        if (bus_changed) begin
          settle_d = 8'd1;
        end else begin
          settle_d = settle_inc[7:0];
          if (settle_inc >= 9'(SETTLE_CYCLES)) state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = WAIT_CHANGE;
      WAIT_CHANGE: begin
        // Compared against the captured anode so a change landing during CAPTURE is not missed.
        if (anode_s != cap_anode) begin
          state_d  = SETTLE;
          settle_d = 8'd1;
        end
      end
    endcase
    if (timeout_hit) state_d = IDLE;

    mask_d = (frame_done || timeout_hit) ? 8'h00 : mask_q;
    if (capture_ok) mask_d = mask_d | (8'b1 << cap_pos);
  end

  always_comb begin
    for (int k = 0; k < 8; k++) frame_digits[4*k +: 4] = pending[k];
    hours_full   = to_bin(pending[5], pending[4]);
    minutes_full = to_bin(pending[3], pending[2]);
    seconds_full = to_bin(pending[1], pending[0]);
    // Blank, undecodable and hex glyphs all sit above 9, so one range test covers them.
    digits_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (pending[k] > 4'd9) digits_ok = 1'b0;
    end
    time_ok = digits_ok && (hours_full <= 8'd23) && (minutes_full <= 8'd59) &&
              (seconds_full <= 8'd59);
  end

  // NOTE: the pending slots are deliberately not reset; the capture mask guards every use,
  // which keeps this storage a plain register file.
  always_ff @(posedge clk) begin
    if (capture_ok) pending[cap_pos] <= dec[3:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      timeout_q   <= '0;
      mask_q      <= '0;
      cap_anode   <= '1;
      digits      <= 32'hEEEEEEEE;
      hours       <= '0;
      minutes     <= '0;
      seconds     <= '0;
      frame_valid <= 1'b0;
      time_valid  <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
      scan_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      mask_q      <= mask_d;
      frame_valid <= frame_done;
      if (capture) cap_anode <= anode_p;
      if (capture_ok) timeout_q <= '0;
      else if (timeout_q != TW'(TIMEOUT_CYCLES)) timeout_q <= timeout_q + 1'b1;
      if (frame_done) begin
        digits     <= frame_digits;
        hours      <= hours_full[4:0];
        minutes    <= minutes_full[5:0];
        seconds    <= seconds_full[5:0];
        time_valid <= time_ok;
      end
      if (capture_ok && dec[4]) seg_err <= 1'b1;
      if (capture && !one_cold) anode_err <= 1'b1;
      if (timeout_hit) scan_lost <= 1'b1;
      else if (capture_ok) scan_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: scans drive the bus, expected frames are queued
// and compared by a monitor whenever frame_valid pulses.
module tb_seg_scan_decoder;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  anode = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic [31:0] digits;
  logic [4:0]  hours;
  logic [5:0]  minutes, seconds;
  logic        frame_valid, time_valid, seg_err, anode_err, scan_lost;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .anode(anode), .seg(seg), .digits(digits),
    .hours(hours), .minutes(minutes), .seconds(seconds), .frame_valid(frame_valid),
    .time_valid(time_valid), .seg_err(seg_err), .anode_err(anode_err), .scan_lost(scan_lost)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic        tv;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      exp_f;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_frames = 0;
  logic [31:0] last_digits = 32'hEEEEEEEE;
  logic [4:0]  last_hours = 5'd0;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'b0000001;
      4'h1: pat = 7'b1001111;
      4'h2: pat = 7'b0010010;
      4'h3: pat = 7'b0000110;
      4'h4: pat = 7'b1001100;
      4'h5: pat = 7'b0100100;
      4'h6: pat = 7'b0100000;
      4'h7: pat = 7'b0001111;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0000100;
      4'hE: pat = 7'b1111111;
      default: pat = 7'b1111000;
    endcase
  endfunction

  task automatic show(input int pos, input logic [3:0] nib, input int hold);
    anode = 8'hFF;
    anode[pos] = 1'b0;
    seg = pat(nib);
    repeat (hold) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] d, input int hold, input int hi, input int lo);
    for (int p = hi; p >= lo; p--) show(p, d[4*p +: 4], hold);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [4:0] h, input logic [5:0] m,
                          input logic [5:0] s, input logic tv);
    frame_t f;
    f.d = d; f.h = h; f.m = m; f.s = s; f.tv = tv;
    exp_q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (reset && frame_valid) begin
      n_frames++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_frame: got digits=%h, required no frame", digits);
      end else begin
        exp_f = exp_q.pop_front();
        if (digits !== exp_f.d) begin
          n_err++; $display("FAIL frame_digits: got %h, required %h", digits, exp_f.d);
        end
        n_vec++;
        if (hours !== exp_f.h) begin
          n_err++; $display("FAIL frame_hours: got %0d, required %0d", hours, exp_f.h);
        end
        n_vec++;
        if (minutes !== exp_f.m) begin
          n_err++; $display("FAIL frame_minutes: got %0d, required %0d", minutes, exp_f.m);
        end
        n_vec++;
        if (seconds !== exp_f.s) begin
          n_err++; $display("FAIL frame_seconds: got %0d, required %0d", seconds, exp_f.s);
        end
        n_vec++;
        if (time_valid !== exp_f.tv) begin
          n_err++; $display("FAIL frame_time_valid: got %b, required %b", time_valid, exp_f.tv);
        end
        last_digits = exp_f.d;
        last_hours  = exp_f.h;
      end
    end
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (digits !== 32'hEEEEEEEE) begin n_err++; $display("FAIL reset_digits: got %h, required eeeeeeee", digits); end
    n_vec++; if ({hours, minutes, seconds} !== 17'd0) begin n_err++; $display("FAIL reset_time: got %0d:%0d:%0d, required 0:0:0", hours, minutes, seconds); end
    n_vec++; if ({frame_valid, time_valid, seg_err, anode_err, scan_lost} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, required 00000", {frame_valid, time_valid, seg_err, anode_err, scan_lost});
    end
  endtask

  task automatic test_time_frame;
    int f0 = n_frames;
    push_exp(32'hEE123456, 5'd12, 6'd34, 6'd56, 1'b1);
    scan(32'hEE123456, 20, 7, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL time_frame_missing: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (n_frames - f0 != 1) begin n_err++; $display("FAIL time_frame_count: got %0d pulses, required 1", n_frames - f0); end
    n_vec++; if ({seg_err, anode_err} !== 2'b00) begin n_err++; $display("FAIL time_frame_errs: got %b, required 00", {seg_err, anode_err}); end
  endtask

  task automatic test_hours_range;
    push_exp(32'hEE250000, 5'd25, 6'd0, 6'd0, 1'b0);
    scan(32'hEE250000, 20, 7, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hours_frame_missing: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL hours_seg_err: got %b, required 0", seg_err); end
  endtask

  task automatic test_bad_segment;
    // Minutes tens is undecodable: 15*10+4 = 154, truncated to 6 bits = 26.
    push_exp(32'hEE12F456, 5'd12, 6'd26, 6'd56, 1'b0);
    scan(32'hEE12F456, 20, 7, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bad_seg_frame_missing: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (seg_err !== 1'b1) begin n_err++; $display("FAIL bad_seg_err: got %b, required 1", seg_err); end
  endtask

  task automatic test_anode_error;
    int f0 = n_frames;
    push_exp(32'hEE201530, 5'd20, 6'd15, 6'd30, 1'b1);
    scan(32'hEE201530, 20, 7, 4);
    anode = 8'b00111111;
    seg = pat(4'h8);
    repeat (20) @(negedge clk);
    n_vec++; if (anode_err !== 1'b1) begin n_err++; $display("FAIL anode_err_flag: got %b, required 1", anode_err); end
    n_vec++; if (n_frames != f0) begin n_err++; $display("FAIL anode_early_frame: got %0d pulses, required 0", n_frames - f0); end
    scan(32'hEE201530, 20, 3, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (n_frames - f0 != 1) begin n_err++; $display("FAIL anode_frame_count: got %0d pulses, required 1", n_frames - f0); end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_settle_window;
    int f0 = n_frames;
    scan(32'h98765432, SETTLE - 1, 7, 0);
    n_vec++; if (n_frames != f0) begin n_err++; $display("FAIL short_hold_frame: got %0d pulses, required 0", n_frames - f0); end
    push_exp(32'h00235959, 5'd23, 6'd59, 6'd59, 1'b1);
    scan(32'h00235959, SETTLE + 2, 7, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (n_frames - f0 != 1) begin n_err++; $display("FAIL settle_frame_count: got %0d pulses, required 1", n_frames - f0); end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_timeout;
    int f0 = n_frames;
    logic [31:0] d_before = last_digits;
    logic [4:0]  h_before = last_hours;
    scan(32'hEE111111, 20, 7, 3);
    repeat (TIMEOUT / 2) @(negedge clk);
    n_vec++; if (scan_lost !== 1'b0) begin n_err++; $display("FAIL early_scan_lost: got %b, required 0", scan_lost); end
    repeat (TIMEOUT / 2 + 20) @(negedge clk);
    n_vec++; if (scan_lost !== 1'b1) begin n_err++; $display("FAIL scan_lost_set: got %b, required 1", scan_lost); end
    n_vec++; if (digits !== d_before) begin n_err++; $display("FAIL timeout_digits: got %h, required %h", digits, d_before); end
    n_vec++; if (hours !== h_before) begin n_err++; $display("FAIL timeout_hours: got %0d, required %0d", hours, h_before); end
    n_vec++; if (n_frames != f0) begin n_err++; $display("FAIL timeout_frame: got %0d pulses, required 0", n_frames - f0); end
    push_exp(32'hEE081522, 5'd8, 6'd15, 6'd22, 1'b1);
    show(7, 4'hE, 20);
    n_vec++; if (scan_lost !== 1'b0) begin n_err++; $display("FAIL scan_lost_clear: got %b, required 0", scan_lost); end
    scan(32'hEE081522, 20, 6, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (n_frames - f0 != 1) begin n_err++; $display("FAIL resume_frame_count: got %0d pulses, required 1", n_frames - f0); end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int f0 = n_frames;
    scan(32'hEE000000, 20, 7, 4);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (digits !== 32'hEEEEEEEE) begin n_err++; $display("FAIL mid_reset_digits: got %h, required eeeeeeee", digits); end
    n_vec++; if ({seg_err, anode_err} !== 2'b00) begin n_err++; $display("FAIL mid_reset_sticky: got %b, required 00", {seg_err, anode_err}); end
    n_vec++; if (n_frames != f0) begin n_err++; $display("FAIL mid_reset_frame: got %0d pulses, required 0", n_frames - f0); end
    push_exp(32'hEE135724, 5'd13, 6'd57, 6'd24, 1'b1);
    scan(32'hEE135724, 20, 7, 0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++; if (n_frames - f0 != 1) begin n_err++; $display("FAIL post_reset_frame_count: got %0d pulses, required 1", n_frames - f0); end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_time_frame();
    test_hours_range();
    test_bad_segment();
    test_anode_error();
    test_settle_window();
    test_timeout();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
